// File: rtl/chip_link_pkg.sv
// Shared constants and width helpers for the chip-link interface blocks.
// The connection id rides in the MSBs of every {id, flit} word sent off-chip.
package chip_link_pkg;

    localparam int FW_DEF      = 59;
    localparam int B_DEF       = 4;
    localparam int CONNECT_DEF = 2;

    // Connection-id width; a lone connection still carries a 1-bit id.
    function automatic int cw_of(input int connect);
        return (connect <= 2) ? 1 : $clog2(connect);
    endfunction

    function automatic int pkt_w(input int fw, input int connect);
        return fw + cw_of(connect);
    endfunction

endpackage

// File: rtl/chip_link_fifo.sv
// Per-connection flit buffer; a push into a full buffer lands only when the
// same cycle also pops, so occupancy stays at B.
module chip_link_fifo
    import chip_link_pkg::*;
#(
    parameter int FW = FW_DEF,
    parameter int B  = B_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [FW-1:0] din,
    input  logic          pop,
    output logic [FW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int AW = $clog2(B);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [FW-1:0] r_mem [B];
    logic          w_push_ok;
    logic          w_pop_ok;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < B; i++) r_mem[i] <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[AW-1:0]] <= din;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/chip_link_arbiter.sv
// Round-robin arbiter funnelling CONNECT buffered NoC connections onto one
// chip send FIFO, with registered {id, flit} output and credit return.
module chip_link_arbiter
    import chip_link_pkg::*;
#(
    parameter int  FW      = FW_DEF,
    parameter int  B       = B_DEF,
    parameter int  CONNECT = CONNECT_DEF,
    localparam int CW      = cw_of(CONNECT),
    localparam int PW      = pkt_w(FW, CONNECT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CONNECT-1:0]    flit_in_wr,
    input  logic [FW*CONNECT-1:0] flit_in,
    output logic [CONNECT-1:0]    credit_out,
    input  logic [CONNECT-1:0]    connect_available,
    input  logic                  send_fifo_full,
    output logic                  data_out_wr,
    output logic [PW-1:0]         data_out,
    output logic [CONNECT-1:0]    overflow_err
);

    logic [CONNECT-1:0][FW-1:0] w_head;
    logic [CONNECT-1:0]         w_empty;
    logic [CONNECT-1:0]         w_full;
    logic [CONNECT-1:0]         w_elig;
    logic [CONNECT-1:0]         w_pop;
    logic [CW-1:0]              w_cand [CONNECT];
    logic                       w_gnt_vld;
    logic [CW-1:0]              w_gnt_idx;

    logic [CW-1:0]              r_rr_ptr;
    logic                       r_armed;
    logic                       r_data_out_wr;
    logic [PW-1:0]              r_data_out;
    logic [CONNECT-1:0]         r_credit;
    logic [CONNECT-1:0]         r_ovf;

    for (genvar j = 0; j < CONNECT; j++) begin : g_conn
        chip_link_fifo #(.FW(FW), .B(B)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (flit_in_wr[j]),
            .din   (flit_in[FW*j +: FW]),
            .pop   (w_pop[j]),
            .dout  (w_head[j]),
            .empty (w_empty[j]),
            .full  (w_full[j])
        );
        assign w_elig[j] = ~w_empty[j] & connect_available[j];
        assign w_pop[j]  = w_gnt_vld && (w_gnt_idx == CW'(j));
        // k-th candidate in round-robin order starting at the pointer
        assign w_cand[j] = CW'((int'(r_rr_ptr) + j) % CONNECT);
    end

    // Scan from the far end so the candidate closest to rr_ptr wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (r_armed && !send_fifo_full) begin
            for (int k = CONNECT - 1; k >= 0; k--) begin
                if (w_elig[w_cand[k]]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = w_cand[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed       <= 1'b0;
            r_rr_ptr      <= '0;
            r_data_out_wr <= 1'b0;
            r_data_out    <= '0;
            r_credit      <= '0;
            r_ovf         <= '0;
        end else begin
            r_armed       <= 1'b1;
            r_data_out_wr <= w_gnt_vld;
            r_credit      <= w_pop;
            r_ovf         <= r_ovf | (flit_in_wr & w_full & ~w_pop);
            if (w_gnt_vld) begin
                r_data_out <= {w_gnt_idx, w_head[w_gnt_idx]};
                r_rr_ptr   <= (w_gnt_idx == CW'(CONNECT - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign data_out_wr  = r_data_out_wr;
    assign data_out     = r_data_out;
    assign credit_out   = r_credit;
    assign overflow_err = r_ovf;

endmodule

// File: tb/tb_chip_link_arbiter.sv
// Directed bench for chip_link_arbiter at default parameters (FW=59, B=4, CONNECT=2).
module tb_chip_link_arbiter;

    localparam int FW = 59;
    localparam int B  = 4;
    localparam int NC = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   flit_in_wr;
    logic [FW*NC-1:0] flit_in;
    logic [NC-1:0]   credit_out;
    logic [NC-1:0]   connect_available;
    logic            send_fifo_full;
    logic            data_out_wr;
    logic [FW:0]     data_out;
    logic [NC-1:0]   overflow_err;

    int errors = 0;
    int checks = 0;

    chip_link_arbiter #(.FW(FW), .B(B), .CONNECT(NC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flit_in_wr        (flit_in_wr),
        .flit_in           (flit_in),
        .credit_out        (credit_out),
        .connect_available (connect_available),
        .send_fifo_full    (send_fifo_full),
        .data_out_wr       (data_out_wr),
        .data_out          (data_out),
        .overflow_err      (overflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        flit_in_wr        = '0;
        flit_in           = '0;
        connect_available = '0;
        send_fifo_full    = 1'b0;
        rst_n             = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        flit_in_wr = '0; flit_in = '0; connect_available = 2'b11; send_fifo_full = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (data_out_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", data_out_wr); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_out); end
        checks++; if (credit_out !== 2'b00) begin errors++; $display("FAIL reset_credit: got %b expected 00", credit_out); end
        checks++; if (overflow_err !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b expected 00", overflow_err); end
        do_reset();
    endtask

    task automatic test_single();
        logic [FW:0] exp;
        do_reset();
        connect_available = 2'b11;
        flit_in_wr = 2'b10;
        flit_in[FW +: FW] = FW'(1);
        tick();
        flit_in_wr = '0;
        checks++; if (data_out_wr !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", data_out_wr); end
        tick();
        exp = {1'b1, FW'(1)};
        checks++; if (data_out_wr !== 1'b1) begin errors++; $display("FAIL single_wr: got %b expected 1", data_out_wr); end
        checks++; if (data_out !== exp) begin errors++; $display("FAIL single_data: got %h expected %h", data_out, exp); end
        checks++; if (credit_out !== 2'b10) begin errors++; $display("FAIL single_credit: got %b expected 10", credit_out); end
        tick();
        checks++; if (data_out_wr !== 1'b0) begin errors++; $display("FAIL single_after_wr: got %b expected 0", data_out_wr); end
        checks++; if (data_out !== exp) begin errors++; $display("FAIL single_hold: got %h expected %h", data_out, exp); end
        checks++; if (credit_out !== 2'b00) begin errors++; $display("FAIL single_credit_pulse: got %b expected 00", credit_out); end
    endtask

    task automatic test_back_to_back();
        logic [FW:0] exp;
        int n, id;
        do_reset();
        connect_available = 2'b11;
        for (int k = 0; k < 14; k++) begin
            if (k < 6) begin
                flit_in_wr = 2'b11;
                flit_in[0 +: FW]  = FW'(32'h100 + k);
                flit_in[FW +: FW] = FW'(32'h200 + k);
            end else begin
                flit_in_wr = '0;
            end
            tick();
            if (k >= 1 && k <= 12) begin
                n = k - 1;
                id = n % 2;
                exp = {1'(id), FW'((id == 0 ? 32'h100 : 32'h200) + n / 2)};
                checks++;
                if (data_out_wr !== 1'b1 || data_out !== exp || credit_out !== (2'b01 << id)) begin
                    errors++;
                    $display("FAIL b2b_out%0d: got wr=%b data=%h credit=%b expected wr=1 data=%h credit=%b",
                             n, data_out_wr, data_out, credit_out, exp, 2'b01 << id);
                end
            end else begin
                checks++;
                if (data_out_wr !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d: got %b expected 0", k, data_out_wr); end
            end
        end
        checks++; if (overflow_err !== 2'b00) begin errors++; $display("FAIL b2b_ovf: got %b expected 00", overflow_err); end
    endtask

    task automatic test_overflow();
        logic [FW:0] exp;
        int cnt;
        do_reset();
        connect_available = 2'b11;
        send_fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            flit_in_wr = 2'b01;
            flit_in[0 +: FW] = FW'(32'h30 + k);
            tick();
        end
        flit_in_wr = '0;
        checks++; if (overflow_err !== 2'b01) begin errors++; $display("FAIL ovf_flag: got %b expected 01", overflow_err); end
        checks++; if (data_out_wr !== 1'b0) begin errors++; $display("FAIL ovf_blocked: got %b expected 0", data_out_wr); end
        send_fifo_full = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (data_out_wr === 1'b1) begin
                exp = {1'b0, FW'(32'h30 + cnt)};
                checks++;
                if (cnt >= 4 || data_out !== exp) begin
                    errors++; $display("FAIL ovf_drain%0d: got %h expected %h", cnt, data_out, exp);
                end
                cnt++;
            end
        end
        checks++; if (cnt !== 4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", cnt); end
        checks++; if (overflow_err !== 2'b01) begin errors++; $display("FAIL ovf_sticky: got %b expected 01", overflow_err); end
    endtask

    task automatic test_avail();
        logic [FW:0] exp;
        int cnt0, cnt1;
        do_reset();
        connect_available = 2'b00;
        for (int k = 0; k < 2; k++) begin
            flit_in_wr = 2'b11;
            flit_in[0 +: FW]  = FW'(32'h40 + k);
            flit_in[FW +: FW] = FW'(32'h48 + k);
            tick();
        end
        flit_in_wr = '0;
        connect_available = 2'b01;
        cnt0 = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (data_out_wr === 1'b1) begin
                exp = {1'b0, FW'(32'h40 + cnt0)};
                checks++;
                if (cnt0 >= 2 || data_out !== exp) begin
                    errors++; $display("FAIL avail_c0_%0d: got %h expected %h", cnt0, data_out, exp);
                end
                cnt0++;
            end
        end
        checks++; if (cnt0 !== 2) begin errors++; $display("FAIL avail_c0_count: got %0d expected 2", cnt0); end
        connect_available = 2'b11;
        cnt1 = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (data_out_wr === 1'b1) begin
                exp = {1'b1, FW'(32'h48 + cnt1)};
                checks++;
                if (cnt1 >= 2 || data_out !== exp) begin
                    errors++; $display("FAIL avail_c1_%0d: got %h expected %h", cnt1, data_out, exp);
                end
                cnt1++;
            end
        end
        checks++; if (cnt1 !== 2) begin errors++; $display("FAIL avail_c1_count: got %0d expected 2", cnt1); end
    endtask

    task automatic test_reset_mid();
        int strobes;
        do_reset();
        connect_available = 2'b00;
        for (int k = 0; k < 5; k++) begin
            flit_in_wr = (k < 2) ? 2'b11 : 2'b01;
            flit_in[0 +: FW]  = FW'(32'h60 + k);
            flit_in[FW +: FW] = FW'(32'h68 + k);
            tick();
        end
        flit_in_wr = '0;
        connect_available = 2'b11;
        tick();
        checks++; if (data_out_wr !== 1'b1 || overflow_err !== 2'b01) begin
            errors++; $display("FAIL rstmid_pre: got wr=%b ovf=%b expected wr=1 ovf=01", data_out_wr, overflow_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (data_out_wr !== 1'b0) begin errors++; $display("FAIL rstmid_wr: got %b expected 0", data_out_wr); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL rstmid_data: got %h expected 0", data_out); end
        checks++; if (credit_out !== 2'b00) begin errors++; $display("FAIL rstmid_credit: got %b expected 00", credit_out); end
        checks++; if (overflow_err !== 2'b00) begin errors++; $display("FAIL rstmid_ovf: got %b expected 00", overflow_err); end
        #1;
        rst_n = 1'b1;
        strobes = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (data_out_wr !== 1'b0) strobes++;
        end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL rstmid_after: got %0d strobes expected 0", strobes); end
    endtask

    task automatic test_simul();
        logic [FW:0] exp;
        int cnt;
        do_reset();
        connect_available = 2'b11;
        send_fifo_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            flit_in_wr = 2'b01;
            flit_in[0 +: FW] = FW'(32'h50 + k);
            tick();
        end
        send_fifo_full = 1'b0;
        flit_in_wr = 2'b01;
        flit_in[0 +: FW] = FW'(32'h54);
        tick();
        exp = {1'b0, FW'(32'h50)};
        checks++; if (overflow_err !== 2'b00) begin errors++; $display("FAIL simul_ovf: got %b expected 00", overflow_err); end
        checks++; if (data_out_wr !== 1'b1 || data_out !== exp) begin
            errors++; $display("FAIL simul_out: got wr=%b data=%h expected wr=1 data=%h", data_out_wr, data_out, exp);
        end
        // Occupancy must still be B: one more write with no pop overflows.
        send_fifo_full = 1'b1;
        flit_in[0 +: FW] = FW'(32'h55);
        tick();
        flit_in_wr = '0;
        checks++; if (overflow_err !== 2'b01) begin errors++; $display("FAIL simul_full: got %b expected 01", overflow_err); end
        send_fifo_full = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (data_out_wr === 1'b1) begin
                exp = {1'b0, FW'(32'h51 + cnt)};
                checks++;
                if (cnt >= 4 || data_out !== exp) begin
                    errors++; $display("FAIL simul_drain%0d: got %h expected %h", cnt, data_out, exp);
                end
                cnt++;
            end
        end
        checks++; if (cnt !== 4) begin errors++; $display("FAIL simul_count: got %0d expected 4", cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_avail();
        test_reset_mid();
        test_simul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
